// File: rtl/sdram_pkg.sv
// Shared encodings and default geometry for the SDRAM-side RAM port logic.
package sdram_pkg;

  localparam int DEF_AW = 10;
  localparam int DEF_DW = 32;
  localparam int DEF_BW = 4;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ACK   = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer
// moves on every grant it issues.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // 1 means r1 was granted last, so r0 wins a tie
  logic r_last;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      unique case (1'b1)
        (i_req == 2'b11): o_gnt = r_last ? 2'b01 : 2'b10;
        default:          o_gnt = i_req;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_last <= 1'b1;
    else if (|o_gnt)
      r_last <= o_gnt[1];
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares RAM port A between two req/ack requesters;
// zero-fills the RAM after every reset.
module dpram_port_arbiter
  import sdram_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int BW = DEF_BW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [BW-1:0] r0_be,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdat,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rdat,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [BW-1:0] r1_be,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdat,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rdat,
  output logic          ram_wren,
  output logic [BW-1:0] ram_byteena,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data,
  input  logic [DW-1:0] ram_q,
  output logic          clr_busy
);

  state_t        r_state;
  logic [AW:0]   r_cnt;
  logic          r_clr_busy;
  logic          r_wren;
  logic [BW-1:0] r_be;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_sel;
  logic          r_is_rd;
  logic          r_ack0;
  logic          r_ack1;
  logic [DW-1:0] r_rdat0;
  logic [DW-1:0] r_rdat1;
  logic [1:0]    w_gnt;
  logic          w_pick1;

  rr_arb2 u_arb (
    .i_clk (clock),
    .i_rst (reset),
    .i_en  (r_state == ST_IDLE),
    .i_req ({r1_req, r0_req}),
    .o_gnt (w_gnt)
  );

  assign w_pick1 = w_gnt[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_CLEAR;
      r_cnt      <= '0;
      r_clr_busy <= 1'b1;
      r_wren     <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_sel      <= 1'b0;
      r_is_rd    <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rdat0    <= '0;
      r_rdat1    <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      unique case (r_state)
        ST_CLEAR: begin
          // counter MSB set: the last word was driven last cycle
          if (r_cnt[AW]) begin
            r_wren     <= 1'b0;
            r_clr_busy <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_wren <= 1'b1;
            r_be   <= '1;
            r_data <= '0;
            r_addr <= r_cnt[AW-1:0];
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (|w_gnt) begin
            r_sel   <= w_pick1;
            r_wren  <= w_pick1 ? r1_we : r0_we;
            r_is_rd <= w_pick1 ? ~r1_we : ~r0_we;
            r_be    <= w_pick1 ? r1_be : r0_be;
            r_addr  <= w_pick1 ? r1_addr : r0_addr;
            r_data  <= w_pick1 ? r1_wdat : r0_wdat;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_wren  <= 1'b0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_is_rd) begin
            if (r_sel) r_rdat1 <= ram_q;
            else       r_rdat0 <= ram_q;
          end
          r_ack0  <= ~r_sel;
          r_ack1  <= r_sel;
          r_state <= ST_ACK;
        end
        ST_ACK: r_state <= ST_IDLE;
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  assign r0_ack      = r_ack0;
  assign r1_ack      = r_ack1;
  assign r0_rdat     = r_rdat0;
  assign r1_rdat     = r_rdat1;
  assign ram_wren    = r_wren;
  assign ram_byteena = r_be;
  assign ram_address = r_addr;
  assign ram_data    = r_data;
  assign clr_busy    = r_clr_busy;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a
// behavioural RAM and an ack scoreboard.
module tb_dpram_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        r0_req, r0_we;
  logic [3:0]  r0_be;
  logic [9:0]  r0_addr;
  logic [31:0] r0_wdat;
  logic        r0_ack;
  logic [31:0] r0_rdat;
  logic        r1_req, r1_we;
  logic [3:0]  r1_be;
  logic [9:0]  r1_addr;
  logic [31:0] r1_wdat;
  logic        r1_ack;
  logic [31:0] r1_rdat;
  logic        ram_wren;
  logic [3:0]  ram_byteena;
  logic [9:0]  ram_address;
  logic [31:0] ram_data;
  logic [31:0] ram_q;
  logic        clr_busy;

  dpram_port_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .r0_req      (r0_req),
    .r0_we       (r0_we),
    .r0_be       (r0_be),
    .r0_addr     (r0_addr),
    .r0_wdat     (r0_wdat),
    .r0_ack      (r0_ack),
    .r0_rdat     (r0_rdat),
    .r1_req      (r1_req),
    .r1_we       (r1_we),
    .r1_be       (r1_be),
    .r1_addr     (r1_addr),
    .r1_wdat     (r1_wdat),
    .r1_ack      (r1_ack),
    .r1_rdat     (r1_rdat),
    .ram_wren    (ram_wren),
    .ram_byteena (ram_byteena),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_q       (ram_q),
    .clr_busy    (clr_busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // RAM with registered output; starts full of junk
  logic [31:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++)
      mem[i] = $urandom | 32'h1;
  end
  always @(posedge clock) begin
    if (ram_wren)
      for (int b = 0; b < 4; b++)
        if (ram_byteena[b])
          mem[ram_address][8*b +: 8] <= ram_data[8*b +: 8];
    ram_q <= mem[ram_address];
  end

  typedef struct {
    int          port;
    bit          rd;
    logic [31:0] rdat;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sh0 = '0;
  logic [31:0] sh1 = '0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic we,
                       input logic [3:0] be,
                       input logic [9:0] a,
                       input logic [31:0] d);
    if (p == 0) begin
      r0_req = 1'b1; r0_we = we; r0_be = be;
      r0_addr = a; r0_wdat = d;
    end else begin
      r1_req = 1'b1; r1_we = we; r1_be = be;
      r1_addr = a; r1_wdat = d;
    end
  endtask

  task automatic push_exp(input int p, input bit rd,
                          input logic [31:0] v,
                          input int c);
    exp_t e;
    e.port = p; e.rd = rd; e.rdat = v; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic run(input int budget);
    exp_t e;
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clock);
      n++;
      if (r0_ack || r1_ack) begin
        e = sb.pop_front();
        chk("ack_port", {r1_ack, r0_ack},
            (e.port == 1) ? 2'b10 : 2'b01);
        chk("ack_cycle", cyc, e.cyc);
        if (e.rd) begin
          if (e.port == 0) sh0 = e.rdat;
          else sh1 = e.rdat;
          chk("rdat", (e.port == 0) ? r0_rdat : r1_rdat,
              e.rdat);
        end
        chk("other_rdat", (e.port == 0) ? r1_rdat : r0_rdat,
            (e.port == 0) ? sh1 : sh0);
        if (r0_ack) r0_req = 1'b0;
        if (r1_ack) r1_req = 1'b0;
      end
    end
    chk("sb_drained", sb.size(), 0);
    sb.delete();
    @(negedge clock);
    chk("ack_after", {r1_ack, r0_ack}, 2'b00);
  endtask

  initial begin
    int c;
    int n;
    reset = 1'b1;
    r0_req = 0; r0_we = 0; r0_be = 0; r0_addr = 0; r0_wdat = 0;
    r1_req = 0; r1_we = 0; r1_be = 0; r1_addr = 0; r1_wdat = 0;
    repeat (3) @(negedge clock);

    chk("rst_ram",
        {ram_data, 15'b0, ram_wren, ram_byteena,
         clr_busy, 1'b0, ram_address},
        {32'h0, 15'b0, 1'b0, 4'h0, 1'b1, 1'b0, 10'h0});
    chk("rst_ack", {r1_ack, r0_ack}, 2'b00);
    chk("rst_rdat", {r1_rdat, r0_rdat}, 64'h0);
    reset = 1'b0;

    for (int k = 0; k < 1024; k++) begin
      @(negedge clock);
      chk("clr_sweep",
          {ram_data, 15'b0, ram_wren, ram_byteena,
           clr_busy, 1'b0, ram_address},
          {32'h0, 15'b0, 1'b1, 4'hF, 1'b1, 1'b0, k[9:0]});
    end
    @(negedge clock);
    chk("clr_done", {clr_busy, ram_wren}, 2'b00);

    // single-port traffic
    drive(0, 1, 4'hF, 10'd5, 32'hDEADBEEF);
    push_exp(0, 0, 0, cyc + 3); run(20);
    drive(0, 0, 4'hF, 10'd5, 32'h0);
    push_exp(0, 1, 32'hDEADBEEF, cyc + 3); run(20);
    drive(1, 1, 4'h2, 10'd5, 32'h0000AA00);
    push_exp(1, 0, 0, cyc + 3); run(20);
    drive(1, 0, 4'hF, 10'd5, 32'h0);
    push_exp(1, 1, 32'hDEADAAEF, cyc + 3); run(20);
    drive(0, 1, 4'h0, 10'd5, 32'h12345678);
    push_exp(0, 0, 0, cyc + 3); run(20);
    drive(0, 0, 4'hF, 10'd5, 32'h0);
    push_exp(0, 1, 32'hDEADAAEF, cyc + 3); run(20);
    drive(0, 1, 4'hF, 10'd9, 32'h0BADF00D);
    push_exp(0, 0, 0, cyc + 3); run(20);
    drive(1, 1, 4'hF, 10'd10, 32'h12345678);
    push_exp(1, 0, 0, cyc + 3); run(20);

    // r1 granted last: r0 wins the tie
    drive(0, 0, 4'hF, 10'd9, 32'h0);
    drive(1, 0, 4'hF, 10'd10, 32'h0);
    push_exp(0, 1, 32'h0BADF00D, cyc + 3);
    push_exp(1, 1, 32'h12345678, cyc + 7);
    run(30);
    drive(0, 0, 4'hF, 10'd10, 32'h0);
    drive(1, 0, 4'hF, 10'd9, 32'h0);
    push_exp(0, 1, 32'h12345678, cyc + 3);
    push_exp(1, 1, 32'h0BADF00D, cyc + 7);
    run(30);
    drive(0, 0, 4'hF, 10'd7, 32'h0);
    push_exp(0, 1, 32'h0, cyc + 3); run(20);
    // r0 granted last: r1 wins the tie
    drive(0, 0, 4'hF, 10'd9, 32'h0);
    drive(1, 0, 4'hF, 10'd5, 32'h0);
    push_exp(1, 1, 32'hDEADAAEF, cyc + 3);
    push_exp(0, 1, 32'h0BADF00D, cyc + 7);
    run(30);

    // requests raised during the clear sweep
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    sh0 = '0; sh1 = '0;
    c = cyc;
    drive(1, 0, 4'hF, 10'd200, 32'h0);
    drive(0, 0, 4'hF, 10'd5, 32'h0);
    push_exp(0, 1, 32'h0, c + 1028);
    push_exp(1, 1, 32'h0, c + 1032);
    run(1100);

    // reset in the WAIT cycle of an r1 read
    drive(1, 1, 4'hF, 10'd200, 32'h55AA55AA);
    push_exp(1, 0, 0, cyc + 3); run(20);
    drive(1, 0, 4'hF, 10'd200, 32'h0);
    push_exp(1, 1, 32'h55AA55AA, cyc + 3); run(20);
    drive(1, 0, 4'hF, 10'd200, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    r1_req = 1'b0;
    sh0 = '0; sh1 = '0;
    chk("abort_ack", {r1_ack, r0_ack}, 2'b00);
    chk("abort_busy", {clr_busy, ram_wren}, 2'b10);
    chk("abort_rdat", r1_rdat, 32'h0);
    @(negedge clock);
    chk("restart_a0",
        {ram_wren, clr_busy, ram_address}, {2'b11, 10'd0});
    @(negedge clock);
    chk("restart_a1",
        {ram_wren, clr_busy, ram_address}, {2'b11, 10'd1});
    n = 0;
    while (clr_busy && n < 1100) begin
      @(negedge clock);
      n++;
    end
    chk("restart_done", clr_busy, 1'b0);
    drive(0, 0, 4'hF, 10'd200, 32'h0);
    push_exp(0, 1, 32'h0, cyc + 3); run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Shares one port of the 1024x32 byte-enable dual-port RAM between two requesters, r0 and r1.
- Each requester uses a req/ack handshake.
- After every reset the block clears the whole RAM to zero, then serves requests with round-robin arbitration.
- It sits between the SDRAM-side cache/buffer logic and the RAM's port A. Port B remains owned by the other clock-side user.

Parameters:
- AW, 10, RAM address width (depth = 2**AW).
- DW, 32, data width.
- BW, 4, byte-enable width (DW/8).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- r0_req  in  1  request; held high until r0_ack.
- r0_we  in  1  1 = write, 0 = read.
- r0_be  in  BW  byte enables for writes.
- r0_addr  in  AW  word address.
- r0_wdat  in  DW  write data.
- r0_ack  out  1  one-cycle completion pulse.
- r0_rdat  out  DW  read data; valid when r0_ack is high after a read, and held until the next r0 read ack.
- r1_req, r1_we, r1_be, r1_addr, r1_wdat, r1_ack, r1_rdat: same as r0, for requester 1.
- ram_wren  out  1  to RAM wren_a.
- ram_byteena  out  BW  to RAM byteena_a.
- ram_address  out  AW  to RAM address_a.
- ram_data  out  DW  to RAM data_a.
- ram_q  in  DW  from RAM q_a; registered in the RAM, valid one cycle after the address.
- clr_busy  out  1  high while the clear sweep is running.

Behaviour:
- Reset values:
  - State = CLEAR, clear counter = 0, clr_busy = 1.
  - ram_wren = 0, ram_byteena = 0, ram_address = 0, ram_data = 0.
  - r0_ack = r1_ack = 0, r0_rdat = r1_rdat = 0.
  - Round-robin pointer favours r0.
- All RAM-side outputs are registered.
- State machine (CLEAR, IDLE, ISSUE, WAIT, ACK):
  - CLEAR: each cycle drive ram_wren = 1, ram_byteena = all ones, ram_data = 0, ram_address = counter, then increment the counter. After address 2**AW-1 has been driven, go to IDLE and drop clr_busy. The sweep takes 2**AW cycles plus 1. Requests raised during CLEAR stay pending and are not acked.
  - IDLE: if any req is high, pick a winner, latch its we/be/addr/wdat into the RAM-side registers, and go to ISSUE. ram_wren = winner's we.
  - ISSUE: RAM-side signals are stable for exactly one cycle. Next state is WAIT. ram_wren returns to 0 on exit.
  - WAIT: ram_q is valid. For a read, capture it into the winner's rdat register. Next state is ACK.
  - ACK: pulse the winner's ack for one cycle. Next state is IDLE.
- Latency from req sampled high in IDLE (cycle 0) to ack is 3 cycles, i.e. ack is high in cycle 3. Peak throughput is one access per 4 cycles.
- Handshake rules:
  - The requester must hold req and its qualifiers stable until ack.
  - The requester must drop req in the cycle after ack; a req still high then is treated as a new request.
  - In the ACK cycle, req from the granted port is ignored.
- Arbitration:
  - If only one port requests, it wins.
  - If both request, the port not granted last wins. The pointer updates on every grant.
- ram_address and ram_data hold their last values while idle; only ram_wren matters.
- A write with be = 0000 still runs the full sequence and is acked; the RAM is unchanged.
- Reset mid-access aborts with no ack. The clear sweep restarts at address 0.
- The non-granted rdat is never disturbed.

Decomposition:
- Shared package (sdram_pkg): state encoding constants (CLEAR/IDLE/ISSUE/WAIT/ACK) and the default AW/DW/BW values.
- One natural sub-module: rr_arb2, a 2-way round-robin grant with a last-grant pointer and a grant-enable input.

Test Plan:
- Reset, no requests -> clr_busy high for 1025 cycles, ram_wren = 1 with be = 1111 and data 0 for addresses 0..1023 in order, then clr_busy = 0 and ram_wren = 0.
- After clear, r0 write addr 5, data 0xDEADBEEF, be 1111, then r0 read addr 5 -> each ack 3 cycles after req; r0_rdat = 0xDEADBEEF in the read ack cycle.
- r1 write addr 5, be 0010, data 0x0000AA00, then r1 read -> r1_rdat = 0xDEADAAEF; r0_rdat unchanged.
- r0 and r1 both request in the same IDLE cycle right after reset -> r0 acked first, r1 acked 4 cycles later. Repeated simultaneous requests alternate grants.
- r0 req asserted during the clear sweep -> no ack until after clr_busy falls. Read of any untouched address returns 0x00000000.
- reset asserted in the WAIT cycle of an r1 read -> no r1_ack, clr_busy = 1 next cycle, sweep restarts at address 0.
